// File: rtl/data_memory_if.sv
// Bus between the datapath and the data memory: address, store data and
// control in; extended load data and status out.
interface data_memory_if;
   logic [31:0] Address;
   logic [31:0] DataWr;
   logic        DMWR;
   logic [2:0]  DMCtrl;
   logic [31:0] DataRd;
   logic        misaligned;
   logic        err_sticky;
   logic        ready;

   modport master (
      output Address, DataWr, DMWR, DMCtrl,
      input  DataRd, misaligned, err_sticky, ready
   );

   modport slave (
      input  Address, DataWr, DMWR, DMCtrl,
      output DataRd, misaligned, err_sticky, ready
   );
endinterface

// File: rtl/data_memory.sv
// Byte-addressable RV32I data memory. Loads are combinational and already
// sign/zero-extended; stores take effect at the rising edge. After reset a
// sweep clears every word before accesses are accepted.
module data_memory #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10,
   parameter bit INIT_CLEAR  = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   data_memory_if.slave bus
);
   typedef enum logic {CLEAR, READY} state_t;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              err_sticky_q, err_sticky_d;
   logic [31:0]       mem [DEPTH_WORDS];

   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              ready;
   logic              misaligned;
   logic [31:0]       rd_word;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       data_rd;
   logic [3:0]        byte_en;
   logic [31:0]       wr_data;
   logic              wr_en;
   logic              unused_addr_bits;

   // Upper address bits are deliberately ignored so addresses wrap.
   assign word_idx         = bus.Address[ADDR_W+1:2];
   assign lane             = bus.Address[1:0];
   assign unused_addr_bits = ^bus.Address[31:ADDR_W+2];
   assign ready            = (state_q == READY);

   // Halfword accesses need an even address, word accesses a multiple of 4.
   assign misaligned = (((bus.DMCtrl == CTRL_H) || (bus.DMCtrl == CTRL_HU)) && bus.Address[0])
                     || ((bus.DMCtrl == CTRL_W) && (bus.Address[1:0] != 2'b00));

   // Select and extend the addressed byte/half/word; zero when not usable.
   assign rd_word = mem[word_idx];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = bus.Address[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      data_rd = '0;
      if (ready && !misaligned) begin
         case (bus.DMCtrl)
            CTRL_B:  data_rd = {{24{rd_byte[7]}}, rd_byte};
            CTRL_BU: data_rd = {24'h0, rd_byte};
            CTRL_H:  data_rd = {{16{rd_half[15]}}, rd_half};
            CTRL_HU: data_rd = {16'h0, rd_half};
            CTRL_W:  data_rd = rd_word;
            default: data_rd = '0;
         endcase
      end
   end

   // Byte enables and lane-replicated store data; invalid codes enable nothing.
   always_comb begin
      byte_en = 4'b0000;
      wr_data = bus.DataWr;
      case (bus.DMCtrl)
         CTRL_B: begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{bus.DataWr[7:0]}};
         end
         CTRL_H: begin
            byte_en = bus.Address[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.DataWr[15:0]}};
         end
         CTRL_W:  byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   assign wr_en = bus.DMWR && ready && !misaligned && (byte_en != 4'b0000);

   // Next state: sweep the array in CLEAR, flag misaligned stores in READY.
   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      err_sticky_d = err_sticky_q;
      if (state_q == CLEAR) begin
         clr_ptr_d = clr_ptr_q + ADDR_W'(1);
         if (clr_ptr_q == LAST_WORD) state_d = READY;
      end else if (bus.DMWR && misaligned) begin
         err_sticky_d = 1'b1;
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q      <= INIT_CLEAR ? CLEAR : READY;
         clr_ptr_q    <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   // Storage: zeroed by the sweep, otherwise written lane by lane.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset term; it is cleared by the sweep instead, keeping it a plain RAM.
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem[clr_ptr_q] <= '0;
         end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
               if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   assign bus.DataRd     = data_rd;
   assign bus.misaligned = misaligned;
   assign bus.err_sticky = err_sticky_q;
   assign bus.ready      = ready;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (16 words). Stimulus pushes expectations
// into a scoreboard tagged with the cycle they belong to; a monitor on the
// falling edge pops and compares them.
module tb_data_memory;
   typedef enum logic [1:0] {S_DATA, S_MIS, S_ERR, S_RDY} sel_t;
   typedef struct {
      string       name;
      sel_t        sel;
      logic [31:0] exp;
      int          cyc;
   } exp_t;

   localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc_q = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   data_memory_if bus ();

   data_memory #(.DEPTH_WORDS(16), .ADDR_W(4), .INIT_CLEAR(1'b1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_q <= cyc_q + 1;

   // Wait for the next rising edge, then drive one access.
   task automatic apply(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wr, input logic [2:0] ctrl);
      @(posedge clk);
      #1;
      bus.Address = addr;
      bus.DataWr  = wdata;
      bus.DMWR    = wr;
      bus.DMCtrl  = ctrl;
   endtask

   // Queue an expectation for the current cycle.
   task automatic chk(input string name, input sel_t sel, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      e.cyc  = cyc_q;
      sb.push_back(e);
   endtask

   // Monitor: compare every expectation due by this cycle.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc_q) begin
            e = sb.pop_front();
            case (e.sel)
               S_DATA:  act = bus.DataRd;
               S_MIS:   act = {31'h0, bus.misaligned};
               S_ERR:   act = {31'h0, bus.err_sticky};
               default: act = {31'h0, bus.ready};
            endcase
            n_vec++;
            if (act !== e.exp) begin
               n_err++;
               $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc_q);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus.Address = '0;
      bus.DataWr  = '0;
      bus.DMWR    = 1'b0;
      bus.DMCtrl  = W;

      // 1. Reset, sweep length, all words read back zero.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", S_RDY, 32'd0);
      chk("rst_err", S_ERR, 32'd0);
      chk("rst_data", S_DATA, 32'd0);
      for (int k = 1; k <= 16; k++) begin
         if (k == 3) begin
            apply(32'h21, 32'hFFFF_FFFF, 1'b1, W);
            chk("mis_in_clear", S_MIS, 32'd1);
         end else begin
            apply(32'h0, 32'h0, 1'b0, W);
         end
         chk($sformatf("sweep_ready_%0d", k), S_RDY, (k == 16) ? 32'd1 : 32'd0);
      end
      chk("err_after_sweep", S_ERR, 32'd0);
      for (int i = 0; i < 16; i++) begin
         apply(32'(4 * i), 32'h0, 1'b0, W);
         chk($sformatf("lw_zero_%0d", i), S_DATA, 32'h0);
      end

      // 2. Word store, then extended loads.
      apply(32'h10, 32'h8765_43A1, 1'b1, W);
      apply(32'h10, 32'h0, 1'b0, B);  chk("lb_10",  S_DATA, 32'hFFFF_FFA1);
      apply(32'h10, 32'h0, 1'b0, BU); chk("lbu_10", S_DATA, 32'h0000_00A1);
      apply(32'h12, 32'h0, 1'b0, H);  chk("lh_12",  S_DATA, 32'hFFFF_8765);
      apply(32'h12, 32'h0, 1'b0, HU); chk("lhu_12", S_DATA, 32'h0000_8765);

      // 3. Partial stores.
      apply(32'h11, 32'h0000_00CC, 1'b1, B);
      apply(32'h10, 32'h0, 1'b0, W);  chk("lw_after_sb", S_DATA, 32'h8765_CCA1);
      apply(32'h11, 32'h0, 1'b0, B);  chk("lb_11", S_DATA, 32'hFFFF_FFCC);
      apply(32'h12, 32'hABCD_1234, 1'b1, H);
      apply(32'h10, 32'h0, 1'b0, W);  chk("lw_after_sh", S_DATA, 32'h1234_CCA1);
      apply(32'h10, 32'h0, 1'b0, HU); chk("lhu_10", S_DATA, 32'h0000_CCA1);

      // 4. Misaligned and invalid accesses.
      apply(32'h20, 32'h1122_3344, 1'b1, W);
      apply(32'h21, 32'hFFFF_FFFF, 1'b1, W);
      chk("sw_21_mis", S_MIS, 32'd1);
      chk("err_before", S_ERR, 32'd0);
      apply(32'h20, 32'h0, 1'b0, W);  chk("lw_20_kept", S_DATA, 32'h1122_3344);
      chk("err_set", S_ERR, 32'd1);
      apply(32'h23, 32'h0, 1'b0, H);  chk("lh_23_zero", S_DATA, 32'h0);
      chk("lh_23_mis", S_MIS, 32'd1);
      apply(32'h23, 32'h0, 1'b0, B);  chk("lb_23", S_DATA, 32'hFFFF_FF11 & 32'h0000_0011 | 32'h0);
      chk("lb_23_aligned", S_MIS, 32'd0);
      apply(32'h22, 32'h0, 1'b0, HU); chk("lhu_22", S_DATA, 32'h0000_1122);
      apply(32'h20, 32'hFFFF_FFFF, 1'b1, 3'b011);
      chk("bad_ctrl_rd", S_DATA, 32'h0);
      apply(32'h20, 32'h0, 1'b0, W);  chk("lw_20_bad_ctrl", S_DATA, 32'h1122_3344);
      apply(32'h24, 32'h5, 1'b1, W);
      apply(32'h24, 32'h0, 1'b0, W);  chk("err_stays", S_ERR, 32'd1);

      // 6. Aliasing and read-during-write.
      apply(32'h40, 32'hDEAD_BEEF, 1'b1, W);
      chk("rdw_old", S_DATA, 32'h0);
      apply(32'h00, 32'h0, 1'b0, W);  chk("alias_lw_00", S_DATA, 32'hDEAD_BEEF);
      apply(32'h40, 32'h0, 1'b0, W);  chk("alias_lw_40", S_DATA, 32'hDEAD_BEEF);

      // 5. Reset mid-sweep; stores during the sweep are dropped.
      apply(32'h0, 32'h0, 1'b0, W);
      rst = 1'b1;
      apply(32'h0, 32'h0, 1'b0, W);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) apply(32'h0, 32'h0, 1'b0, W);
      rst = 1'b1;
      apply(32'h0, 32'h0, 1'b0, W);
      chk("midrst_ready", S_RDY, 32'd0);
      chk("midrst_err", S_ERR, 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k == 10)      apply(32'h00, 32'hA5A5_A5A5, 1'b1, W);
         else if (k == 14) apply(32'h10, 32'h5A5A_5A5A, 1'b1, W);
         else              apply(32'h0, 32'h0, 1'b0, W);
         chk($sformatf("resweep_ready_%0d", k), S_RDY, (k == 16) ? 32'd1 : 32'd0);
      end
      apply(32'h00, 32'h0, 1'b0, W);  chk("sweep_sw_dropped_0", S_DATA, 32'h0);
      apply(32'h10, 32'h0, 1'b0, W);  chk("sweep_sw_dropped_10", S_DATA, 32'h0);
      chk("err_after_resweep", S_ERR, 32'd0);

      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
         n_err += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
